// File: rtl/apu_pkg.sv
// Shared constants and helpers for the VGA-timed audio unit.
package apu_pkg;

  localparam int          LFSR_W      = 13;
  localparam logic [12:0] LFSR_SEED   = 13'h0001;
  // Taps for x^13+x^12+x^11+x^8+1, i.e. feedback from bits 12, 11, 10 and 7.
  localparam logic [12:0] LFSR_TAPS   = 13'h1C80;
  localparam int          VGA_H_TOTAL = 800;
  localparam int          VGA_V_TOTAL = 525;

  function automatic logic [31:0] rest_period(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  function automatic int env_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/apu_tone_ch.sv
// One square-wave tone channel: scanline period counter, phase and decaying envelope.
module apu_tone_ch
  import apu_pkg::*;
#(
  parameter int PERIOD_W = 9,
  parameter int ENV_W    = 5,
  parameter int ENV_DIV  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_line_tick,
  input  logic                i_frame_tick,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_trig,
  output logic                o_phase,
  output logic [ENV_W-1:0]    o_env
);

  localparam logic [PERIOD_W-1:0] REST     = PERIOD_W'(rest_period(PERIOD_W));
  localparam logic [ENV_W-1:0]    ENV_MAX  = ENV_W'(env_max(ENV_W));
  localparam logic [3:0]          DIV_LAST = 4'(ENV_DIV - 1);

  logic [PERIOD_W-1:0] r_cnt;
  logic                r_phase;
  logic [ENV_W-1:0]    r_env;
  logic [3:0]          r_div;

  // Using >= lets the counter recover at once when the period shrinks below it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (i_period == REST) begin
      r_cnt   <= '0;
      r_phase <= 1'b0;
    end else if (i_line_tick) begin
      if (r_cnt >= i_period) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + PERIOD_W'(1);
      end
    end
  end

  // A trigger outranks a coincident decrement; retrigger leaves the phase alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_env <= '0;
      r_div <= '0;
    end else if (i_trig) begin
      r_env <= ENV_MAX;
      r_div <= '0;
    end else if (i_frame_tick) begin
      if (r_div == DIV_LAST) begin
        r_div <= '0;
        if (r_env != '0) r_env <= r_env - ENV_W'(1);
      end else begin
        r_div <= r_div + 4'd1;
      end
    end
  end

  assign o_phase = r_phase;
  assign o_env   = r_env;

endmodule

// File: rtl/apu_mixer_nch.sv
// Multi-channel tone + noise audio unit mixed into a scanline-carrier PWM bit.
module apu_mixer_nch
  import apu_pkg::*;
#(
  parameter int NUM_TONE  = 2,
  parameter int PERIOD_W  = 9,
  parameter int ENV_W     = 5,
  parameter int ENV_DIV   = 1,
  parameter int NOISE_DIV = 2,
  parameter int MIX_SCALE = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [9:0]                   x,
  input  logic [9:0]                   y,
  input  logic [NUM_TONE*PERIOD_W-1:0] tone_period,
  input  logic [NUM_TONE-1:0]          tone_trig,
  input  logic                         noise_trig,
  input  logic [NUM_TONE:0]            ch_mute,
  output logic [NUM_TONE:0]            ch_active,
  output logic                         audio_out
);

  localparam int NCH   = NUM_TONE + 1;
  localparam int SUM_W = ENV_W + $clog2(NCH);
  localparam int MIX_W = SUM_W + MIX_SCALE;
  localparam int CMP_W = (MIX_W > 10) ? MIX_W : 10;

  localparam logic [ENV_W-1:0] ENV_MAX   = ENV_W'(env_max(ENV_W));
  localparam logic [3:0]       DIV_LAST  = 4'(ENV_DIV - 1);
  localparam logic [2:0]       NDIV_LAST = 3'(NOISE_DIV - 1);

  logic                 r_xZeroPrev;
  logic                 w_xZero;
  logic                 w_lineTick;
  logic                 w_frameTick;
  logic [NCH-1:0]       w_phase;
  logic [NCH*ENV_W-1:0] w_envFlat;
  logic [SUM_W-1:0]     w_sum;
  logic [MIX_W-1:0]     r_mixLatch;
  logic [LFSR_W-1:0]    r_lfsr;
  logic [2:0]           r_noiseDiv;
  logic [ENV_W-1:0]     r_noiseEnv;
  logic [3:0]           r_noiseEnvDiv;

  // Only the first cycle of x==0 counts, so a stalled hpos cannot multi-tick.
  assign w_xZero     = (x == 10'd0);
  assign w_lineTick  = w_xZero && !r_xZeroPrev;
  assign w_frameTick = w_lineTick && (y == 10'd0);

  for (genvar k = 0; k < NUM_TONE; k++) begin : g_tone
    apu_tone_ch #(
      .PERIOD_W(PERIOD_W),
      .ENV_W   (ENV_W),
      .ENV_DIV (ENV_DIV)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_line_tick (w_lineTick),
      .i_frame_tick(w_frameTick),
      .i_period    (tone_period[k*PERIOD_W +: PERIOD_W]),
      .i_trig      (tone_trig[k]),
      .o_phase     (w_phase[k]),
      .o_env       (w_envFlat[k*ENV_W +: ENV_W])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr     <= LFSR_SEED;
      r_noiseDiv <= '0;
    end else if (w_lineTick) begin
      if (r_noiseDiv == NDIV_LAST) begin
        r_noiseDiv <= '0;
        r_lfsr     <= {r_lfsr[LFSR_W-2:0], ^(r_lfsr & LFSR_TAPS)};
      end else begin
        r_noiseDiv <= r_noiseDiv + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_noiseEnv    <= '0;
      r_noiseEnvDiv <= '0;
    end else if (noise_trig) begin
      r_noiseEnv    <= ENV_MAX;
      r_noiseEnvDiv <= '0;
    end else if (w_frameTick) begin
      if (r_noiseEnvDiv == DIV_LAST) begin
        r_noiseEnvDiv <= '0;
        if (r_noiseEnv != '0) r_noiseEnv <= r_noiseEnv - ENV_W'(1);
      end else begin
        r_noiseEnvDiv <= r_noiseEnvDiv + 4'd1;
      end
    end
  end

  assign w_phase[NUM_TONE]                 = r_lfsr[0];
  assign w_envFlat[NUM_TONE*ENV_W +: ENV_W] = r_noiseEnv;

  for (genvar k = 0; k < NCH; k++) begin : g_active
    assign ch_active[k] = (w_envFlat[k*ENV_W +: ENV_W] != '0);
  end

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NCH; i++) begin
      if (w_phase[i] && !ch_mute[i]) w_sum = w_sum + SUM_W'(w_envFlat[i*ENV_W +: ENV_W]);
    end
  end

  // The latch samples pre-tick channel state and holds the duty for the whole line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_xZeroPrev <= 1'b0;
      r_mixLatch  <= '0;
      audio_out   <= 1'b0;
    end else begin
      r_xZeroPrev <= w_xZero;
      if (w_lineTick) r_mixLatch <= MIX_W'(w_sum) << MIX_SCALE;
      audio_out <= (CMP_W'(x) < CMP_W'(r_mixLatch));
    end
  end

endmodule

// File: tb/tb_apu_mixer_nch.sv
// Scoreboard bench for apu_mixer_nch using abbreviated, directly driven hpos/vpos sweeps.
module tb_apu_mixer_nch;

  localparam int SEL_AUDIO  = 0;
  localparam int SEL_ACTIVE = 1;
  localparam int SEL_LFSR   = 2;
  localparam logic [8:0] REST = 9'h1FF;

  logic        clk;
  logic        rst_n;
  logic [9:0]  x;
  logic [9:0]  y;
  logic [17:0] tone_period;
  logic [1:0]  tone_trig;
  logic        noise_trig;
  logic [2:0]  ch_mute;
  logic [2:0]  ch_active;
  logic        audio_out;

  string qName[$];
  int    qSel[$];
  int    qExp[$];
  int    numCompared;
  int    numMismatched;

  apu_mixer_nch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .y          (y),
    .tone_period(tone_period),
    .tone_trig  (tone_trig),
    .noise_trig (noise_trig),
    .ch_mute    (ch_mute),
    .ch_active  (ch_active),
    .audio_out  (audio_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic [9:0] xv, input logic [9:0] yv);
    x = xv;
    y = yv;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int sel, input int exp);
    qName.push_back(name);
    qSel.push_back(sel);
    qExp.push_back(exp);
  endtask

  task automatic setPeriod(input int ch, input logic [8:0] val);
    tone_period[ch*9 +: 9] = val;
  endtask

  // Monitor: drains the expectation queue against the DUT on every falling edge.
  initial begin
    string nm;
    int    sel;
    int    exp;
    int    act;
    numCompared   = 0;
    numMismatched = 0;
    forever begin
      @(negedge clk);
      while (qSel.size() > 0) begin
        nm  = qName.pop_front();
        sel = qSel.pop_front();
        exp = qExp.pop_front();
        case (sel)
          SEL_AUDIO:  act = int'(audio_out);
          SEL_ACTIVE: act = int'(ch_active);
          default:    act = int'(dut.r_lfsr);
        endcase
        numCompared++;
        if (act != exp) begin
          numMismatched++;
          $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [12:0] m;
    logic [12:0] pre;
    int          mdiv;
    int          thr;

    rst_n       = 1'b0;
    x           = '0;
    y           = '0;
    tone_period = {REST, REST};
    tone_trig   = 2'b11;
    noise_trig  = 1'b1;
    ch_mute     = 3'b000;

    // Reset held with triggers and frame ticks present.
    repeat (5) applyStimulus(10'd0, 10'd0);
    checkOutput("reset_hold_audio", SEL_AUDIO, 0);
    checkOutput("reset_hold_active", SEL_ACTIVE, 0);
    rst_n      = 1'b1;
    tone_trig  = 2'b00;
    noise_trig = 1'b0;
    applyStimulus(10'd5, 10'd1);
    checkOutput("reset_audio", SEL_AUDIO, 0);
    checkOutput("reset_active", SEL_ACTIVE, 0);
    checkOutput("reset_lfsr", SEL_LFSR, 1);

    // Tone ch0, half-period 3: phase high on lines 5..8 after the trigger.
    setPeriod(0, 9'd3);
    tone_trig = 2'b01;
    applyStimulus(10'd5, 10'd1);
    tone_trig = 2'b00;
    checkOutput("tone_trig_active", SEL_ACTIVE, 1);
    for (int n = 1; n <= 12; n++) begin
      applyStimulus(10'd0, 10'd1);
      applyStimulus(10'd123, 10'd1);
      checkOutput("tone_p3_inside", SEL_AUDIO, (n >= 5 && n <= 8) ? 1 : 0);
      applyStimulus(10'd124, 10'd1);
      checkOutput("tone_p3_edge", SEL_AUDIO, 0);
    end

    // Frames: one decay, then a trigger coincident with a frame tick.
    setPeriod(0, 9'd200);
    applyStimulus(10'd0, 10'd0);
    applyStimulus(10'd123, 10'd0);
    checkOutput("frame1_inside", SEL_AUDIO, 1);
    applyStimulus(10'd124, 10'd0);
    checkOutput("frame1_edge", SEL_AUDIO, 0);
    tone_trig = 2'b01;
    applyStimulus(10'd0, 10'd0);
    tone_trig = 2'b00;
    applyStimulus(10'd119, 10'd0);
    checkOutput("decay30_inside", SEL_AUDIO, 1);
    applyStimulus(10'd120, 10'd0);
    checkOutput("decay30_edge", SEL_AUDIO, 0);
    applyStimulus(10'd0, 10'd1);
    applyStimulus(10'd123, 10'd1);
    checkOutput("trig_beats_decay", SEL_AUDIO, 1);
    applyStimulus(10'd124, 10'd1);
    checkOutput("trig_beats_decay_edge", SEL_AUDIO, 0);

    // Decay from 31: duty drops 4 px per frame, active falls on the 31st frame.
    for (int k = 1; k <= 31; k++) begin
      thr = 4 * (32 - k);
      applyStimulus(10'd0, 10'd0);
      applyStimulus(10'(thr - 1), 10'd0);
      checkOutput("decay_inside", SEL_AUDIO, 1);
      applyStimulus(10'(thr), 10'd0);
      checkOutput("decay_edge", SEL_AUDIO, 0);
      checkOutput("decay_active", SEL_ACTIVE, (k < 31) ? 1 : 0);
    end
    applyStimulus(10'd0, 10'd1);
    applyStimulus(10'd1, 10'd1);
    checkOutput("decayed_silent", SEL_AUDIO, 0);

    // Rest: ch1 triggered but parked at all-ones period.
    setPeriod(0, REST);
    tone_trig = 2'b10;
    applyStimulus(10'd5, 10'd1);
    tone_trig = 2'b00;
    checkOutput("rest_active", SEL_ACTIVE, 3'b010);
    for (int n = 0; n < 3; n++) begin
      applyStimulus(10'd0, 10'd1);
      applyStimulus(10'd1, 10'd1);
      checkOutput("rest_silent", SEL_AUDIO, 0);
    end

    // Mute: ch1 toggling every line contributes nothing while muted.
    ch_mute = 3'b010;
    setPeriod(1, 9'd0);
    for (int n = 0; n < 4; n++) begin
      applyStimulus(10'd0, 10'd1);
      applyStimulus(10'd1, 10'd1);
      checkOutput("mute_silent", SEL_AUDIO, 0);
    end
    checkOutput("mute_active", SEL_ACTIVE, 3'b010);
    ch_mute = 3'b000;
    applyStimulus(10'd0, 10'd1);
    applyStimulus(10'd1, 10'd1);
    checkOutput("unmute_low_phase", SEL_AUDIO, 0);
    applyStimulus(10'd0, 10'd1);
    applyStimulus(10'd123, 10'd1);
    checkOutput("unmute_high_phase", SEL_AUDIO, 1);

    // Reset mid-line while the duty would otherwise be high.
    rst_n = 1'b0;
    applyStimulus(10'd50, 10'd1);
    checkOutput("midline_reset_audio", SEL_AUDIO, 0);
    checkOutput("midline_reset_active", SEL_ACTIVE, 0);
    checkOutput("midline_reset_lfsr", SEL_LFSR, 1);
    rst_n = 1'b1;
    setPeriod(1, REST);

    // Noise: full LFSR period against a reference register, shift every 2 lines.
    noise_trig = 1'b1;
    applyStimulus(10'd5, 10'd1);
    noise_trig = 1'b0;
    checkOutput("noise_active", SEL_ACTIVE, 3'b100);
    m    = 13'h0001;
    mdiv = 0;
    for (int n = 1; n <= 16382; n++) begin
      pre = m;
      if (mdiv == 1) begin
        m    = {m[11:0], m[12] ^ m[11] ^ m[10] ^ m[7]};
        mdiv = 0;
      end else begin
        mdiv++;
      end
      applyStimulus(10'd0, 10'd1);
      checkOutput("lfsr_step", SEL_LFSR, int'(m));
      applyStimulus(10'd123, 10'd1);
      checkOutput("noise_audio", SEL_AUDIO, int'(pre[0]));
    end
    checkOutput("lfsr_wrap", SEL_LFSR, 1);

    // Period shrink 200 -> 5 with the counter at 100 wraps on the next line.
    ch_mute = 3'b100;
    setPeriod(0, 9'd200);
    tone_trig = 2'b01;
    applyStimulus(10'd5, 10'd1);
    tone_trig = 2'b00;
    for (int n = 0; n < 100; n++) begin
      applyStimulus(10'd0, 10'd1);
      applyStimulus(10'd1, 10'd1);
    end
    checkOutput("shrink_pre_silent", SEL_AUDIO, 0);
    setPeriod(0, 9'd5);
    applyStimulus(10'd0, 10'd1);
    applyStimulus(10'd123, 10'd1);
    checkOutput("shrink_wrap_line", SEL_AUDIO, 0);
    applyStimulus(10'd0, 10'd1);
    applyStimulus(10'd123, 10'd1);
    checkOutput("shrink_after_wrap", SEL_AUDIO, 1);

    // All three channels at full amplitude: sum 93, duty edge at 372.
    rst_n = 1'b0;
    applyStimulus(10'd5, 10'd1);
    rst_n = 1'b1;
    setPeriod(0, 9'd0);
    setPeriod(1, 9'd0);
    ch_mute    = 3'b000;
    tone_trig  = 2'b11;
    noise_trig = 1'b1;
    applyStimulus(10'd5, 10'd1);
    tone_trig  = 2'b00;
    noise_trig = 1'b0;
    checkOutput("all_active", SEL_ACTIVE, 3'b111);
    applyStimulus(10'd0, 10'd1);
    applyStimulus(10'd123, 10'd1);
    checkOutput("noise_only_inside", SEL_AUDIO, 1);
    applyStimulus(10'd124, 10'd1);
    checkOutput("noise_only_edge", SEL_AUDIO, 0);
    applyStimulus(10'd0, 10'd1);
    applyStimulus(10'd371, 10'd1);
    checkOutput("full_mix_inside", SEL_AUDIO, 1);
    applyStimulus(10'd372, 10'd1);
    checkOutput("full_mix_edge", SEL_AUDIO, 0);

    repeat (2) @(negedge clk);
    #1;
    if (qSel.size() != 0) begin
      numMismatched++;
      $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", qSel.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", numCompared, numMismatched);
    $finish;
  end

endmodule

// File: doc/apu_mixer_nch.md
Name: apu_mixer_nch

Overview:
- Parametrised multi-channel audio unit for the VGA game top. It synthesises NUM_TONE square-wave tone channels and one LFSR noise channel.
- Each channel has a frame-rate decaying envelope. Channels are mixed into a single 1-bit PWM audio output whose carrier is the VGA scanline (x sweep).
- Timing is derived purely from hpos/vpos. It sits beside the video pipeline; the game logic drives periods and per-channel triggers (music sequencer, sound effects).

Parameters:
- NUM_TONE, 2, number of square-wave tone channels (1..4)
- PERIOD_W, 9, width of the tone half-period, in scanlines
- ENV_W, 5, envelope amplitude width; max = 2^ENV_W-1
- ENV_DIV, 1, frames per envelope decrement step (1..15)
- NOISE_DIV, 2, scanlines per LFSR shift (1..7)
- MIX_SCALE, 2, left-shift applied to the mix sum before the PWM compare

Ports:
- clk  in  1  pixel clock
- rst_n  in  1  synchronous, active-low reset
- x  in  10  VGA hpos (0..799)
- y  in  10  VGA vpos (0..524)
- tone_period  in  NUM_TONE*PERIOD_W  per-channel half-period; all-ones = rest
- tone_trig  in  NUM_TONE  1-cycle pulse; restarts channel k envelope
- noise_trig  in  1  1-cycle pulse; restarts noise envelope
- ch_mute  in  NUM_TONE+1  per-channel mute; bit NUM_TONE = noise
- ch_active  out  NUM_TONE+1  1 while that channel's envelope is non-zero
- audio_out  out  1  registered PWM audio bit

Behaviour:
- Ticks (combinational from inputs):
  - line_tick = (x==0)
  - frame_tick = (x==0 && y==0)
- Reset (rst_n==0 at posedge): all counters 0, phases 0, envelopes 0, lfsr = 13'h0001, mix_latch 0, audio_out 0, ch_active 0. Reset mid-line or mid-note silences immediately on the next edge.
- Tone channel k, on line_tick:
  - If cnt_k >= period_k: cnt_k <= 0 and phase_k toggles.
  - Otherwise cnt_k increments.
  - The ">=" compare recovers when the period shrinks below the current count.
  - Output frequency = line_rate / (2*(period+1)).
  - period == all-ones: counter holds at 0, phase forced 0 (rest).
- Noise channel:
  - An internal div counter shifts the lfsr every NOISE_DIV line_ticks.
  - Polynomial x^13+x^12+x^11+x^8+1, Fibonacci: fb = l[12]^l[11]^l[10]^l[7]; lfsr <= {l[11:0], fb}.
  - Noise phase = lfsr[0]. The all-zero state is unreachable from the seed.
- Envelopes, one per channel:
  - Trigger pulse: env <= max, and the decay divider for that channel clears.
  - On frame_tick, the divider advances; every ENV_DIV frames, env decrements, saturating at 0.
  - A trigger on the same cycle as a decrement: trigger wins.
  - A trigger while env is non-zero retriggers to max. The tone phase and counter are not reset (phase-continuous).
  - ch_active[k] = (env_k != 0), registered with env.
- Mix, computed once per line:
  - amp_k = (phase_k && !ch_mute[k]) ? env_k : 0.
  - sum = Σ amp_k, width ENV_W + clog2(NUM_TONE+1), no overflow.
  - mix_latch <= sum << MIX_SCALE, captured on line_tick using pre-tick channel state.
  - The latch keeps the duty constant across the line.
- Output: audio_out <= (x < mix_latch), registered, one cycle after the x it reflects.
  - Duty per line = mix_latch/800.
  - With defaults the max sum is 93<<2 = 372 < 800, so there is no clipping.
- Tick detection:
  - x/y are sampled every clk.
  - If x stalls at 0 for several cycles, only the first cycle of x==0 counts. This uses a registered previous-x-was-zero flag, which resets to 0.

Decomposition:
- Package apu_pkg holds:
  - LFSR seed/taps constants
  - REST period constant (all-ones, width-generic function)
  - ENV_MAX function of ENV_W
  - VGA_H_TOTAL = 800, VGA_V_TOTAL = 525
- Sub-module apu_tone_ch: period counter, phase and envelope for one tone channel, generated NUM_TONE times.
- Noise channel and mixer live in the top.

Test Plan:
- Reset: hold rst_n=0 for 5 clks with triggers active -> audio_out=0, ch_active=0, lfsr=0x0001 after release.
- Tone period: tone_period[0]=3, trig ch0, sweep lines -> phase0 toggles every 4 lines; audio_out high for x<124 (31<<2) on phase-high lines, 0 otherwise.
- Envelope decay: ENV_DIV=1, trig at frame 0 -> ch_active[0] falls after exactly 31 frame_ticks; duty decreases by 4 px per frame.
- Rest/mute: period=9'h1FF -> phase stays 0, audio_out 0 despite trig. ch_mute[1]=1 with ch1 triggered -> no contribution, ch_active[1] still 1.
- Noise: noise_trig, NOISE_DIV=2 -> lfsr sequence 0x0001, 0x0002, 0x0004, … advances every 2 lines; compare against a reference-model LFSR for 8191 shifts, period 8191.
- Collisions: trig coincident with frame_tick -> env=31, not 30. Period reduced from 200 to 5 while cnt=100 -> wrap on the next line_tick. All channels max-amplitude high -> sum 93, audio_out high for x<372.
